// File: rtl/divider_pkg.sv
// Shared types for the radix-2 restoring divider.
// Holds the control FSM state encoding.
package divider_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/divider_if.sv
// Start/done request bus of the divider.
// master: start,a,b out; busy,done,q,r,div_by_zero in.
interface divider_if #(
  parameter int length = 16
) ();

  logic              start;
  logic [length-1:0] a;
  logic [length-1:0] b;
  logic              busy;
  logic              done;
  logic [length-1:0] q;
  logic [length-1:0] r;
  logic              div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, div_by_zero
  );

endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration, purely combinational.
// rem_i/bit_i/dvs_i in; rem_o (next remainder), qbit_o out.
module divider_step #(
  parameter int length = 16
) (
  input  logic [length:0]   rem_i,
  input  logic              bit_i,
  input  logic [length-1:0] dvs_i,
  output logic [length:0]   rem_o,
  output logic              qbit_o
);

  logic [length:0] sh;
  logic [length:0] dvs_x;
  logic            ge;

  // partial remainder stays below the divisor, so its MSB is always 0
  logic unused_msb;
  assign unused_msb = rem_i[length];

  assign sh     = {rem_i[length-1:0], bit_i};
  assign dvs_x  = {1'b0, dvs_i};
  assign ge     = (sh >= dvs_x);
  assign rem_o  = ge ? (sh - dvs_x) : sh;
  assign qbit_o = ge;

endmodule

// File: rtl/divider.sv
// Sequential unsigned divider, one quotient bit per clock.
// clk, rst_n plain; bus (slave) carries start/a/b and results.
module divider
  import divider_pkg::*;
#(
  parameter int length = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  divider_if.slave bus
);

  localparam int CW = $clog2(length + 1);

  div_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [length-1:0] dvd_q, dvd_d;
  logic [length-1:0] dvs_q, dvs_d;
  logic [length:0]   rem_q, rem_d;
  logic [length-1:0] quo_q, quo_d;
  logic [length-1:0] res_q, res_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;

  logic [length:0]   rem_nx;
  logic              qbit;

  divider_step #(
    .length (length)
  ) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[length-1]),
    .dvs_i  (dvs_q),
    .rem_o  (rem_nx),
    .qbit_o (qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          dvd_d   = bus.a;
          dvs_d   = bus.b;
          rem_d   = '0;
          cnt_d   = CW'(length);
        end
      end
      RUN: begin
        // dividend register doubles as the quotient
        dvd_d = {dvd_q[length-2:0], qbit};
        rem_d = rem_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          quo_d   = {dvd_q[length-2:0], qbit};
          res_d   = rem_nx[length-1:0];
          dbz_d   = (dvs_q == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = done_q;
  assign bus.q           = quo_q;
  assign bus.r           = res_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the 16-bit divider.
// Drives via divider_if master side; checks with assertions.
module tb_divider;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  divider_if #(.length(16)) bus ();

  divider #(
    .length (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // raise start, let one edge accept it, drop start
  task automatic start_op(input logic [15:0] a,
                          input logic [15:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 1);
  endtask

  // returns edges from accept to done and busy samples
  task automatic wait_done(output int lat,
                           output int bcnt);
    lat  = 0;
    bcnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (bus.done) break;
      if (bus.busy) bcnt++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
    chk("busy_low_at_done", 32'(bus.busy), 0);
  endtask

  task automatic run(input string tag,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic [15:0] eq,
                     input logic [15:0] er,
                     input logic        edz);
    int lat, bcnt;
    start_op(a, b);
    wait_done(lat, bcnt);
    chk({tag, "_lat"}, lat, 16);
    chk({tag, "_q"}, 32'(bus.q), 32'(eq));
    chk({tag, "_r"}, 32'(bus.r), 32'(er));
    chk({tag, "_dz"}, 32'(bus.div_by_zero), 32'(edz));
  endtask

  initial begin
    int lat, bcnt, ndone;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_q", 32'(bus.q), 0);
    chk("rst_r", 32'(bus.r), 0);
    chk("rst_dz", 32'(bus.div_by_zero), 0);
    rst_n = 1'b1;
    tick();

    // 100 / 7 with busy-length check
    start_op(16'd100, 16'd7);
    wait_done(lat, bcnt);
    chk("b7_lat", lat, 16);
    chk("b7_busy_cycles", bcnt, 16);
    chk("b7_q", 32'(bus.q), 14);
    chk("b7_r", 32'(bus.r), 2);
    chk("b7_dz", 32'(bus.div_by_zero), 0);
    tick();
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("q_held", 32'(bus.q), 14);

    run("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    tick();
    run("3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
    tick();
    run("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
    tick();
    run("5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    tick();

    // start while busy is ignored
    start_op(16'd100, 16'd7);
    repeat (3) tick();
    bus.start = 1'b1;
    bus.a     = 16'd9;
    bus.b     = 16'd2;
    tick();
    bus.start = 1'b0;
    lat = 4;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) break;
      tick();
      lat++;
    end
    chk("ign_lat", lat, 16);
    chk("ign_q", 32'(bus.q), 14);
    chk("ign_r", 32'(bus.r), 2);
    ndone = 0;
    repeat (24) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("ign_no_second_done", ndone, 0);

    // back-to-back: start held in the done cycle
    start_op(16'd100, 16'd7);
    wait_done(lat, bcnt);
    chk("bb1_q", 32'(bus.q), 14);
    start_op(16'd50, 16'd6);
    chk("bb_held_q", 32'(bus.q), 14);
    chk("bb_held_r", 32'(bus.r), 2);
    wait_done(lat, bcnt);
    chk("bb2_lat", lat, 16);
    chk("bb2_q", 32'(bus.q), 8);
    chk("bb2_r", 32'(bus.r), 2);
    tick();

    // reset mid-operation
    start_op(16'd100, 16'd7);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_q", 32'(bus.q), 0);
    chk("abort_r", 32'(bus.r), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    ndone = 0;
    repeat (24) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run("fresh", 16'd50, 16'd6, 16'd8, 16'd2, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
